qar_uart485_fifo: RTL and testbench

//   Next-generation RS-485 UART for qar_core peripherals: parametrised character width, TX/RX FIFOs,
//   bit-period divider, half-duplex DE/RE sequencing with lead/turnaround, and an idle-line interrupt.

---
 rtl/qar_uart485_fifo.sv | 386 ++++++++++++++++++++++++++++++++++++++
 tb/tb_qar_uart485_fifo.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qar_uart485_fifo.sv
// qar_uart485_fifo: RS-485 half-duplex UART with TX/RX FIFOs, a per-frame bit-period
// divider, DE/RE sequencing (lead bit and turnaround), and an idle-line interrupt.
// Optional feature macro: QAR_UART_PARITY_EN adds one parity bit after the data bits
// (even parity, or odd when parity_odd_i=1). Without it no parity bit is framed.
module qar_uart485_fifo #(
  parameter int DATA_BITS  = 8,
  parameter int TX_DEPTH   = 8,
  parameter int RX_DEPTH   = 8,
  parameter int DIV_WIDTH  = 16,
  parameter int TURN_BITS  = 1,
  parameter int IDLE_CHARS = 2
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [DIV_WIDTH-1:0]         clk_div_i,
  input  logic                         parity_odd_i,
  input  logic                         tx_valid_i,
  output logic                         tx_ready_o,
  input  logic [DATA_BITS-1:0]         tx_data_i,
  output logic                         rx_valid_o,
  input  logic                         rx_ready_i,
  output logic [DATA_BITS-1:0]         rx_data_o,
  output logic [$clog2(TX_DEPTH):0]    tx_level_o,
  output logic [$clog2(RX_DEPTH):0]    rx_level_o,
  output logic                         rx_overrun_o,
  output logic                         rx_frame_err_o,
  output logic                         idle_irq_o,
  input  logic                         idle_ack_i,
  output logic                         uart_tx_o,
  input  logic                         uart_rx_i,
  output logic                         uart_de_o,
  output logic                         uart_re_o
);

  localparam int TXA = $clog2(TX_DEPTH);
  localparam int RXA = $clog2(RX_DEPTH);
`ifdef QAR_UART_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif
  localparam int FRAME_BITS = DATA_BITS + 2 + PAR_BITS;
  localparam int IDLE_BITS  = IDLE_CHARS * FRAME_BITS;
  localparam logic [DIV_WIDTH-1:0] MIN_DIV = DIV_WIDTH'(4);
  localparam logic [DIV_WIDTH-1:0] ONE_DIV = DIV_WIDTH'(1);

  typedef enum logic [2:0] {
    TX_IDLE, TX_LEAD, TX_START, TX_DATA, TX_PARITY, TX_STOP, TX_TURN
  } txState_t;

  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP
  } rxState_t;

  // Divider values below 4 are clamped so mid-bit sampling always has room.
  logic [DIV_WIDTH-1:0] divEff;
  assign divEff = (clk_div_i < MIN_DIV) ? MIN_DIV : clk_div_i;

  // ---------------- TX FIFO ----------------
  logic [DATA_BITS-1:0] txMem_q [TX_DEPTH];
  logic [TXA-1:0]       txWr_q, txRd_q;
  logic [TXA:0]         txCnt_q;
  logic                 txFull, txEmpty, txPush, txPop;
  logic [DATA_BITS-1:0] txHead;

  assign txFull  = (txCnt_q == (TXA+1)'(TX_DEPTH));
  assign txEmpty = (txCnt_q == '0);
  assign txPush  = tx_valid_i && !txFull;
  assign txHead  = txMem_q[txRd_q];

  // TX FIFO storage and pointers; the serialiser pops as it enters START.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      txWr_q  <= '0;
      txRd_q  <= '0;
      txCnt_q <= '0;
    end else begin
      if (txPush) begin
        txMem_q[txWr_q] <= tx_data_i;
        txWr_q          <= txWr_q + TXA'(1);
      end
      if (txPop) begin
        txRd_q <= txRd_q + TXA'(1);
      end
      txCnt_q <= txCnt_q + (TXA+1)'(txPush) - (TXA+1)'(txPop);
    end
  end

  // ---------------- TX serialiser ----------------
  txState_t             txState_q;
  logic [DIV_WIDTH-1:0] txDiv_q, txCyc_q;
  logic [7:0]           txBit_q;
  logic [DATA_BITS-1:0] txShift_q;
  logic                 txPar_q;
  logic                 uartTx_q, de_q;
  logic                 txBitEnd;

  assign txBitEnd = (txCyc_q == txDiv_q - ONE_DIV);
  assign txPop    = txBitEnd && !txEmpty &&
                    ((txState_q == TX_LEAD) || (txState_q == TX_STOP));

  // TX state machine with registered line and driver-enable outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      txState_q <= TX_IDLE;
      txDiv_q   <= MIN_DIV;
      txCyc_q   <= '0;
      txBit_q   <= '0;
      txShift_q <= '0;
      txPar_q   <= 1'b0;
      uartTx_q  <= 1'b1;
      de_q      <= 1'b0;
    end else begin
      if (txState_q == TX_IDLE || txBitEnd) txCyc_q <= '0;
      else                                  txCyc_q <= txCyc_q + ONE_DIV;
      case (txState_q)
        TX_IDLE: begin
          if (!txEmpty) begin
            txDiv_q   <= divEff;
            txState_q <= TX_LEAD;
            de_q      <= 1'b1;
            uartTx_q  <= 1'b1;
          end
        end
        TX_LEAD: begin
          if (txBitEnd) begin
            txState_q <= TX_START;
            uartTx_q  <= 1'b0;
            txShift_q <= txHead;
            txPar_q   <= (^txHead) ^ parity_odd_i;
          end
        end
        TX_START: begin
          if (txBitEnd) begin
            txState_q <= TX_DATA;
            uartTx_q  <= txShift_q[0];
            txShift_q <= txShift_q >> 1;
            txBit_q   <= '0;
          end
        end
        TX_DATA: begin
          if (txBitEnd) begin
            if (txBit_q == 8'(DATA_BITS-1)) begin
`ifdef QAR_UART_PARITY_EN
              txState_q <= TX_PARITY;
              uartTx_q  <= txPar_q;
`else
              txState_q <= TX_STOP;
              uartTx_q  <= 1'b1;
`endif
            end else begin
              txBit_q   <= txBit_q + 8'd1;
              uartTx_q  <= txShift_q[0];
              txShift_q <= txShift_q >> 1;
            end
          end
        end
        TX_PARITY: begin
          if (txBitEnd) begin
            txState_q <= TX_STOP;
            uartTx_q  <= 1'b1;
          end
        end
        TX_STOP: begin
          if (txBitEnd) begin
            if (!txEmpty) begin
              txState_q <= TX_START;
              uartTx_q  <= 1'b0;
              txShift_q <= txHead;
              txPar_q   <= (^txHead) ^ parity_odd_i;
            end else begin
              txState_q <= TX_TURN;
              txBit_q   <= '0;
            end
          end
        end
        TX_TURN: begin
          if (txBitEnd) begin
            if (txBit_q == 8'(TURN_BITS-1)) begin
              txState_q <= TX_IDLE;
              de_q      <= 1'b0;
            end else begin
              txBit_q <= txBit_q + 8'd1;
            end
          end
        end
        default: begin
          txState_q <= TX_IDLE;
          de_q      <= 1'b0;
          uartTx_q  <= 1'b1;
        end
      endcase
    end
  end

`ifndef QAR_UART_PARITY_EN
  logic unused_par;
  assign unused_par = txPar_q;
`endif

  // ---------------- RX deserialiser ----------------
  logic                 rxMeta_q, rxSync_q, rxPrev_q, rxFall;
  rxState_t             rxState_q;
  logic [DIV_WIDTH-1:0] rxDiv_q, rxCyc_q, rxHalf;
  logic [3:0]           rxBit_q;
  logic [DATA_BITS-1:0] rxShift_q, rxPushData_q;
  logic                 rxParErr_q, rxPush_q, rxFrameErr_q;
  logic                 rxSample;

  assign rxFall   = rxPrev_q && !rxSync_q;
  assign rxHalf   = (rxDiv_q >> 1) - ONE_DIV;
  assign rxSample = (rxCyc_q == rxDiv_q - ONE_DIV);

  // Two-flop synchroniser plus a delayed copy for falling-edge detection.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rxMeta_q <= 1'b1;
      rxSync_q <= 1'b1;
      rxPrev_q <= 1'b1;
    end else begin
      rxMeta_q <= uart_rx_i;
      rxSync_q <= rxMeta_q;
      rxPrev_q <= rxSync_q;
    end
  end

  // RX state machine; push and frame-error strobes are registered one cycle after the stop sample.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rxState_q    <= RX_IDLE;
      rxDiv_q      <= MIN_DIV;
      rxCyc_q      <= '0;
      rxBit_q      <= '0;
      rxShift_q    <= '0;
      rxParErr_q   <= 1'b0;
      rxPush_q     <= 1'b0;
      rxPushData_q <= '0;
      rxFrameErr_q <= 1'b0;
    end else begin
      rxPush_q     <= 1'b0;
      rxFrameErr_q <= 1'b0;
      case (rxState_q)
        RX_IDLE: begin
          rxCyc_q <= '0;
          if (rxFall) begin
            rxState_q  <= RX_START;
            rxDiv_q    <= divEff;
            rxParErr_q <= 1'b0;
          end
        end
        RX_START: begin
          if (rxCyc_q == rxHalf) begin
            rxCyc_q <= '0;
            rxBit_q <= '0;
            rxState_q <= rxSync_q ? RX_IDLE : RX_DATA;
          end else begin
            rxCyc_q <= rxCyc_q + ONE_DIV;
          end
        end
        RX_DATA: begin
          if (rxSample) begin
            rxCyc_q   <= '0;
            rxShift_q <= {rxSync_q, rxShift_q[DATA_BITS-1:1]};
            if (rxBit_q == 4'(DATA_BITS-1)) begin
`ifdef QAR_UART_PARITY_EN
              rxState_q <= RX_PARITY;
`else
              rxState_q <= RX_STOP;
`endif
            end else begin
              rxBit_q <= rxBit_q + 4'd1;
            end
          end else begin
            rxCyc_q <= rxCyc_q + ONE_DIV;
          end
        end
        RX_PARITY: begin
          if (rxSample) begin
            rxCyc_q    <= '0;
            rxParErr_q <= (rxSync_q != ((^rxShift_q) ^ parity_odd_i));
            rxState_q  <= RX_STOP;
          end else begin
            rxCyc_q <= rxCyc_q + ONE_DIV;
          end
        end
        RX_STOP: begin
          if (rxSample) begin
            rxCyc_q   <= '0;
            rxState_q <= RX_IDLE;
            if (rxSync_q && !rxParErr_q) begin
              rxPush_q     <= 1'b1;
              rxPushData_q <= rxShift_q;
            end else begin
              rxFrameErr_q <= 1'b1;
            end
          end else begin
            rxCyc_q <= rxCyc_q + ONE_DIV;
          end
        end
        default: rxState_q <= RX_IDLE;
      endcase
    end
  end

  // ---------------- RX FIFO ----------------
  logic [DATA_BITS-1:0] rxMem_q [RX_DEPTH];
  logic [RXA-1:0]       rxWr_q, rxRd_q;
  logic [RXA:0]         rxCnt_q;
  logic                 rxFull, rxEmpty, rxPop, rxPushOk, overrun_q;

  assign rxFull   = (rxCnt_q == (RXA+1)'(RX_DEPTH));
  assign rxEmpty  = (rxCnt_q == '0);
  assign rxPop    = rx_ready_i && !rxEmpty;
  assign rxPushOk = rxPush_q && (!rxFull || rxPop);

  // RX FIFO; a push into a full FIFO survives only if a pop frees a slot the same cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rxWr_q    <= '0;
      rxRd_q    <= '0;
      rxCnt_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      overrun_q <= rxPush_q && rxFull && !rxPop;
      if (rxPushOk) begin
        rxMem_q[rxWr_q] <= rxPushData_q;
        rxWr_q          <= rxWr_q + RXA'(1);
      end
      if (rxPop) begin
        rxRd_q <= rxRd_q + RXA'(1);
      end
      rxCnt_q <= rxCnt_q + (RXA+1)'(rxPushOk) - (RXA+1)'(rxPop);
    end
  end

  // ---------------- Idle-line detector ----------------
  logic                 idleArmed_q, irq_q;
  logic [DIV_WIDTH-1:0] idleCyc_q;
  logic [15:0]          idleBits_q;

  // Counts quiet bit times after a received character; the later set assignment beats the ack.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      idleArmed_q <= 1'b0;
      idleCyc_q   <= '0;
      idleBits_q  <= '0;
      irq_q       <= 1'b0;
    end else begin
      if (idle_ack_i) irq_q <= 1'b0;
      if (rxPush_q) begin
        idleArmed_q <= 1'b1;
        idleCyc_q   <= '0;
        idleBits_q  <= '0;
      end else if (rxFall) begin
        idleCyc_q  <= '0;
        idleBits_q <= '0;
      end else if (idleArmed_q && (rxState_q == RX_IDLE) && rxSync_q) begin
        if (idleCyc_q == rxDiv_q - ONE_DIV) begin
          idleCyc_q <= '0;
          if (idleBits_q == 16'(IDLE_BITS-1)) begin
            idleBits_q  <= '0;
            idleArmed_q <= 1'b0;
            irq_q       <= 1'b1;
          end else begin
            idleBits_q <= idleBits_q + 16'd1;
          end
        end else begin
          idleCyc_q <= idleCyc_q + ONE_DIV;
        end
      end
    end
  end

  assign tx_ready_o     = !txFull;
  assign tx_level_o     = txCnt_q;
  assign rx_valid_o     = !rxEmpty;
  assign rx_data_o      = rxEmpty ? '0 : rxMem_q[rxRd_q];
  assign rx_level_o     = rxCnt_q;
  assign rx_overrun_o   = overrun_q;
  assign rx_frame_err_o = rxFrameErr_q;
  assign idle_irq_o     = irq_q;
  assign uart_tx_o      = uartTx_q;
  assign uart_de_o      = de_q;
  assign uart_re_o      = !de_q;

endmodule

// File: tb/tb_qar_uart485_fifo.sv
// Self-checking bench for qar_uart485_fifo: loopback bursts with random data and divider,
// bench-driven frames for overrun/framing/glitch cases, idle interrupt, and mid-frame reset.
module tb_qar_uart485_fifo;

  localparam int DB   = 8;
  localparam int TURN = 1;
`ifdef QAR_UART_PARITY_EN
  localparam int FRAME = DB + 3;
`else
  localparam int FRAME = DB + 2;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] clkDiv;
  logic        parOdd;
  logic        txValid, txReady;
  logic [7:0]  txData;
  logic        rxValid, rxReady;
  logic [7:0]  rxData;
  logic [3:0]  txLevel, rxLevel;
  logic        rxOverrun, rxFrameErr, idleIrq, idleAck;
  logic        uartTx, uartDe, uartRe;
  logic        loopEn, benchRx, rxLine;

  int compared   = 0;
  int mismatched = 0;
  int frameErrCnt = 0;
  int overrunCnt  = 0;
  int deLen = 0;
  byte unsigned expQ[$];
  byte unsigned burstQ[$];
  int expDeQ[$];

  assign rxLine = loopEn ? uartTx : benchRx;

  always #5 clk = ~clk;

  qar_uart485_fifo dut (
    .clk_i(clk), .rst_i(rst), .clk_div_i(clkDiv), .parity_odd_i(parOdd),
    .tx_valid_i(txValid), .tx_ready_o(txReady), .tx_data_i(txData),
    .rx_valid_o(rxValid), .rx_ready_i(rxReady), .rx_data_o(rxData),
    .tx_level_o(txLevel), .rx_level_o(rxLevel),
    .rx_overrun_o(rxOverrun), .rx_frame_err_o(rxFrameErr),
    .idle_irq_o(idleIrq), .idle_ack_i(idleAck),
    .uart_tx_o(uartTx), .uart_rx_i(rxLine), .uart_de_o(uartDe), .uart_re_o(uartRe)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Receive scoreboard: every popped character must be the oldest expected one.
  always @(negedge clk) begin
    if (!rst && rxValid && rxReady) begin
      if (expQ.size() == 0) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL rxUnexpected: got %0d, expected no character", rxData);
      end else begin
        checkOutput("rxData", rxData, expQ.pop_front());
      end
    end
  end

  // Driver-enable monitor: RE inverse of DE, line high when not driving, burst length scoreboard.
  always @(negedge clk) begin
    if (rst) begin
      deLen = 0;
    end else begin
      checkOutput("reInverse", uartRe, !uartDe);
      if (!uartDe) checkOutput("txIdleHigh", uartTx, 1);
      if (uartDe) begin
        deLen++;
      end else if (deLen != 0) begin
        if (expDeQ.size() == 0) begin
          compared++;
          mismatched++;
          $display("[TB] FAIL deUnexpected: got burst of %0d cycles, expected none", deLen);
        end else begin
          checkOutput("deLength", deLen, expDeQ.pop_front());
        end
        deLen = 0;
      end
    end
  end

  // Pulse counters for error strobes.
  always @(negedge clk) begin
    if (!rst && rxFrameErr) frameErrCnt++;
    if (!rst && rxOverrun)  overrunCnt++;
  end

  task automatic waitDe(input logic level, input int limit, input string name);
    int n = 0;
    while (uartDe !== level && n < limit) begin
      tick();
      n++;
    end
    if (uartDe !== level) checkOutput(name, uartDe, level);
  endtask

  task automatic doReset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  function automatic int effDiv(input int d);
    return (d < 4) ? 4 : d;
  endfunction

  function automatic logic parityBit(input byte unsigned d, input logic odd);
    int ones = 0;
    for (int i = 0; i < DB; i++) ones += d[i];
    return ((ones % 2) == 1) ^ odd;
  endfunction

  // Sends burstQ through the loopback path and records what the receiver and DE must show.
  task automatic applyStimulus(input int div);
    int n = burstQ.size();
    int e = effDiv(div);
    clkDiv = 16'(div);
    expDeQ.push_back(e * (1 + n * FRAME + TURN));
    foreach (burstQ[i]) begin
      expQ.push_back(burstQ[i]);
      txValid = 1'b1;
      txData  = burstQ[i];
      tick();
    end
    txValid = 1'b0;
    checkOutput("txLevelLoaded", txLevel, n);
    waitDe(1'b1, 10, "deRiseTimeout");
    waitDe(1'b0, e * (n * FRAME + 4) + 50, "deFallTimeout");
    repeat (2 * e) tick();
    checkOutput("txLevelDrained", txLevel, 0);
    checkOutput("rxDrained", expQ.size(), 0);
  endtask

  task automatic sendFrame(input byte unsigned d, input logic stopBit, input int div);
    benchRx = 1'b0;
    repeat (div) tick();
    for (int i = 0; i < DB; i++) begin
      benchRx = d[i];
      repeat (div) tick();
    end
`ifdef QAR_UART_PARITY_EN
    benchRx = parityBit(d, parOdd);
    repeat (div) tick();
`endif
    benchRx = stopBit;
    repeat (div) tick();
    benchRx = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    int waitCnt;
    logic seenSet;
    rst = 1'b1; clkDiv = 16'd16; parOdd = 1'b0;
    txValid = 1'b0; txData = '0; rxReady = 1'b1; idleAck = 1'b0;
    loopEn = 1'b1; benchRx = 1'b1;
    tick(); tick();
    rst = 1'b0;

    // Reset state.
    checkOutput("rstTxReady", txReady, 1);
    checkOutput("rstRxValid", rxValid, 0);
    checkOutput("rstRxData", rxData, 0);
    checkOutput("rstTxLevel", txLevel, 0);
    checkOutput("rstRxLevel", rxLevel, 0);
    checkOutput("rstUartTx", uartTx, 1);
    checkOutput("rstDe", uartDe, 0);
    checkOutput("rstIrq", idleIrq, 0);

    // Two-character loopback, then a four-character back-to-back burst.
    burstQ = '{8'h33, 8'h55};
    applyStimulus(16);
    burstQ = '{8'hA1, 8'h0F, 8'hF0, 8'h7E};
    applyStimulus(16);

    // Random bursts with random divider, including clamped small values.
    for (int k = 0; k < 6; k++) begin
      burstQ.delete();
      n = $urandom_range(1, 4);
      for (int i = 0; i < n; i++) burstQ.push_back(8'($urandom));
      applyStimulus((k == 0) ? 2 : $urandom_range(2, 20));
    end

    // Overrun: nine frames into an eight-deep RX FIFO with no pops.
    loopEn = 1'b0; rxReady = 1'b0; clkDiv = 16'd16;
    overrunCnt = 0;
    for (int i = 0; i < 9; i++) begin
      byte unsigned b = 8'($urandom);
      if (i < 8) expQ.push_back(b);
      sendFrame(b, 1'b1, 16);
    end
    repeat (8) tick();
    checkOutput("rxLevelFull", rxLevel, 8);
    checkOutput("rxValidFull", rxValid, 1);
    checkOutput("overrunPulses", overrunCnt, 1);
    rxReady = 1'b1;
    repeat (12) tick();
    checkOutput("rxLevelAfterPop", rxLevel, 0);
    checkOutput("rxOverrunDrained", expQ.size(), 0);

    // Framing error on a zero stop bit, then a short glitch that must not start a frame.
    rxReady = 1'b0; frameErrCnt = 0;
    sendFrame(8'h5C, 1'b0, 16);
    repeat (4) tick();
    benchRx = 1'b1;
    repeat (8) tick();
    checkOutput("frameErrPulses", frameErrCnt, 1);
    checkOutput("frameErrLevel", rxLevel, 0);
    benchRx = 1'b0;
    repeat (5) tick();
    benchRx = 1'b1;
    repeat (48) tick();
    checkOutput("glitchNoErr", frameErrCnt, 1);
    checkOutput("glitchLevel", rxLevel, 0);
    rxReady = 1'b1;

    // Idle interrupt after two quiet character times, ack clears, set beats ack.
    loopEn = 1'b1;
    doReset();
    checkOutput("irqAfterReset", idleIrq, 0);
    rxReady = 1'b0;
    clkDiv = 16'd16;
    expQ.push_back(8'h0A);
    expDeQ.push_back(16 * (1 + FRAME + TURN));
    txValid = 1'b1; txData = 8'h0A;
    tick();
    txValid = 1'b0;
    waitCnt = 0;
    while (!rxValid && waitCnt < 400) begin tick(); waitCnt++; end
    checkOutput("idleRxArrived", rxValid, 1);
    repeat (FRAME * 2 * 16 - 20) tick();
    checkOutput("idleNotEarly", idleIrq, 0);
    waitCnt = 0;
    while (!idleIrq && waitCnt < 60) begin tick(); waitCnt++; end
    checkOutput("idleSet", idleIrq, 1);
    rxReady = 1'b1;
    idleAck = 1'b1;
    tick();
    idleAck = 1'b0;
    checkOutput("idleAcked", idleIrq, 0);
    idleAck = 1'b1;
    expQ.push_back(8'hC3);
    expDeQ.push_back(16 * (1 + FRAME + TURN));
    txValid = 1'b1; txData = 8'hC3;
    tick();
    txValid = 1'b0;
    seenSet = 1'b0;
    waitCnt = 0;
    while (!seenSet && waitCnt < 1000) begin
      tick();
      waitCnt++;
      if (idleIrq) seenSet = 1'b1;
    end
    checkOutput("idleSetWinsAck", seenSet, 1);
    tick();
    checkOutput("idleAckNextCycle", idleIrq, 0);
    idleAck = 1'b0;
    checkOutput("idleRxDrained", expQ.size(), 0);

    // Reset in the middle of a data bit aborts the frame on the next cycle.
    for (int i = 0; i < 3; i++) begin
      txValid = 1'b1; txData = 8'(8'h90 + i);
      tick();
    end
    txValid = 1'b0;
    waitDe(1'b1, 10, "midRstDeRise");
    repeat (16 * 2 + 40) tick();
    rst = 1'b1;
    tick();
    checkOutput("midRstUartTx", uartTx, 1);
    checkOutput("midRstDe", uartDe, 0);
    checkOutput("midRstTxLevel", txLevel, 0);
    checkOutput("midRstRxLevel", rxLevel, 0);
    rst = 1'b0;
    repeat (200) tick();
    checkOutput("midRstNoRx", rxValid, 0);

`ifdef QAR_UART_PARITY_EN
    // Odd parity on 0x07 (three ones) must put a 0 in the parity slot.
    parOdd = 1'b1; clkDiv = 16'd16;
    expQ.push_back(8'h07);
    expDeQ.push_back(16 * (1 + FRAME + TURN));
    txValid = 1'b1; txData = 8'h07;
    tick();
    txValid = 1'b0;
    waitDe(1'b1, 10, "parDeRise");
    repeat (16 * (2 + DB) + 8) tick();
    checkOutput("parityBitOdd", uartTx, parityBit(8'h07, 1'b1));
    waitDe(1'b0, 400, "parDeFall");
    repeat (32) tick();
    checkOutput("parityRxDrained", expQ.size(), 0);
`endif

    repeat (4) tick();
    checkOutput("deQueueDrained", expDeQ.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
